// File: rtl/pulse_period_meter_pkg.sv
// Shared definitions for the pulse period meter: FSM state encoding and
// event-mode constants.
package pulse_period_meter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      TIMEOUT = 2'd2
   } state_t;

   localparam logic MODE_PULSE  = 1'b1;
   localparam logic MODE_TOGGLE = 1'b0;

endpackage

// File: rtl/pulse_period_meter_sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous input followed by a delay flop
// for edge detection.
module sync_edge_detect
   import pulse_period_meter_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic din,
   input  logic mode,
   output logic rise,
   output logic fall,
   output logic any
);

   logic sync1;
   logic sync2;
   logic delay;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         delay <= 1'b0;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
         delay <= sync2;
      end
   end

   assign rise = sync2 & ~delay;
   assign fall = ~sync2 & delay;
   // any is the event for the selected mode: rising edges only, or both edges
   assign any  = (mode == MODE_PULSE) ? rise : (rise | fall);

endmodule

// File: rtl/pulse_period_meter.sv
// Measures the clk-cycle distance between consecutive events on an
// asynchronous input, with lock detection and a no-event timeout.
module pulse_period_meter
   import pulse_period_meter_pkg::*;
#(
   parameter int CNT_WIDTH = 16,
   parameter int PULSEMODE = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 sig_in,
   output logic [CNT_WIDTH-1:0] period,
   output logic                 period_valid,
   output logic                 locked,
   output logic                 timeout
);

   localparam logic EVT_MODE = (PULSEMODE != 0) ? MODE_PULSE : MODE_TOGGLE;

   state_t               state;
   state_t               next_state;
   logic [CNT_WIDTH-1:0] cnt;
   logic                 first_meas;
   logic                 evt;
   logic                 rise_edge;
   logic                 fall_edge;
   logic                 unused_edges;

   logic                 load_one;
   logic                 inc;
   logic                 capture;
   logic                 go_timeout;
   logic                 leave_timeout;

   sync_edge_detect u_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (sig_in),
      .mode (EVT_MODE),
      .rise (rise_edge),
      .fall (fall_edge),
      .any  (evt)
   );

   assign unused_edges = rise_edge ^ fall_edge;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state    = state;
      load_one      = 1'b0;
      inc           = 1'b0;
      capture       = 1'b0;
      go_timeout    = 1'b0;
      leave_timeout = 1'b0;
      case (state)
         IDLE: begin
            if (evt) begin
               next_state = MEASURE;
               load_one   = 1'b1;
            end
         end
         MEASURE: begin
            // an event coinciding with saturation is still a measurement
            if (evt) begin
               capture  = 1'b1;
               load_one = 1'b1;
            end else if (cnt == '1) begin
               next_state = TIMEOUT;
               go_timeout = 1'b1;
            end else begin
               inc = 1'b1;
            end
         end
         TIMEOUT: begin
            if (evt) begin
               next_state    = MEASURE;
               load_one      = 1'b1;
               leave_timeout = 1'b1;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt          <= '0;
         period       <= '0;
         period_valid <= 1'b0;
         locked       <= 1'b0;
         timeout      <= 1'b0;
         first_meas   <= 1'b0;
      end else begin
         period_valid <= capture;

         if (load_one) begin
            cnt <= CNT_WIDTH'(1);
         end else if (inc) begin
            cnt <= cnt + CNT_WIDTH'(1);
         end

         // period still holds the previous measurement when comparing
         if (capture) begin
            period     <= cnt;
            locked     <= ~first_meas & (cnt == period);
            first_meas <= 1'b0;
         end else if (load_one) begin
            first_meas <= 1'b1;
         end

         if (go_timeout) begin
            timeout <= 1'b1;
            locked  <= 1'b0;
         end else if (leave_timeout) begin
            timeout <= 1'b0;
         end
      end
   end

endmodule
